// File: rtl/global_hist_ctrl_if.sv
// Fetch/execute side bundle of the global history controller.
// The master drives predict/resolve events. The controller (slave) returns the history state.
interface global_hist_ctrl_if #(
    parameter int HIST_W       = 2,
    parameter int MAX_INFLIGHT = 3
);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic              branchF;
    logic              predTakenF;
    logic              branchE;
    logic              isTakenE;
    logic              mispredictE;
    logic              flush;
    logic [HIST_W-1:0] history;
    logic [HIST_W-1:0] arch_history;
    logic [CNT_W-1:0]  inflight;
    logic              full;
    logic              underflow;

    modport master (
        output branchF, predTakenF, branchE, isTakenE, mispredictE, flush,
        input  history, arch_history, inflight, full, underflow
    );

    modport slave (
        input  branchF, predTakenF, branchE, isTakenE, mispredictE, flush,
        output history, arch_history, inflight, full, underflow
    );
endinterface

// File: rtl/global_hist_ctrl.sv
// Global branch-history controller with architectural and speculative shift registers.
// Define GHR_SPEC_EN for fetch-time speculative update with repair; otherwise history is resolve-time only.
module global_hist_ctrl #(
    parameter int HIST_W       = 2,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic               clk,
    input  logic               reset,
    global_hist_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    // Newest outcome enters at bit 0; the oldest bit falls off the top.
    function automatic logic [HIST_W-1:0] shift_in(input logic [HIST_W-1:0] h, input logic b);
        logic [HIST_W:0] t;
        t = {h, b};
        return t[HIST_W-1:0];
    endfunction

    logic [HIST_W-1:0] arch_q;
    logic [HIST_W-1:0] arch_next;

    always_comb begin
        arch_next = bus.branchE ? shift_in(arch_q, bus.isTakenE) : arch_q;
    end

    always_ff @(posedge clk) begin
        if (reset) arch_q <= '0;
        else       arch_q <= arch_next;
    end

    assign bus.arch_history = arch_q;

`ifdef GHR_SPEC_EN
    logic [HIST_W-1:0] hist_q;
    logic [HIST_W-1:0] hist_next;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_next;
    logic              uf_q;
    logic              full_w;
    logic              predict;
    logic              retire;
    logic              repair;

    assign full_w  = (cnt_q == CNT_W'(MAX_INFLIGHT));
    assign predict = bus.branchF && !full_w;
    // A resolve with nothing in flight must not wrap the counter.
    assign retire  = bus.branchE && (cnt_q != '0);
    assign repair  = (bus.branchE && bus.mispredictE) || bus.flush;

    always_comb begin
        hist_next = hist_q;
        cnt_next  = cnt_q;
        if (repair) begin
            hist_next = arch_next;
            cnt_next  = '0;
        end else begin
            if (predict) hist_next = shift_in(hist_q, bus.predTakenF);
            if (predict && !retire)      cnt_next = cnt_q + 1'b1;
            else if (!predict && retire) cnt_next = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            cnt_q  <= '0;
            uf_q   <= 1'b0;
        end else begin
            hist_q <= hist_next;
            cnt_q  <= cnt_next;
            if (bus.branchE && (cnt_q == '0)) uf_q <= 1'b1;
        end
    end

    assign bus.history   = hist_q;
    assign bus.inflight  = cnt_q;
    assign bus.full      = full_w;
    assign bus.underflow = uf_q;
`else
    logic unused_inputs;
    assign unused_inputs = &{1'b0, bus.branchF, bus.predTakenF, bus.mispredictE, bus.flush};

    assign bus.history   = arch_q;
    assign bus.inflight  = '0;
    assign bus.full      = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule
